// File: rtl/dcache_ctrl_if.sv
// CPU data-port and backing-memory signals of the data cache, bundled as one interface.
// The slave modport is the cache side. The master modport is the CPU/memory side.
interface dcache_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              memwrite;
  logic              MemtoRegM;
  logic [ADDR_W-1:0] dataadr;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              MemReady;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  memwrite, MemtoRegM, dataadr, writedata, mem_rdata, mem_ack,
    output readdata, MemReady, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output memwrite, MemtoRegM, dataadr, writedata, mem_rdata, mem_ack,
    input  readdata, MemReady, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with a req/ack backing memory.
// Define DCACHE_STATS_EN to add the hit_count/miss_count statistics outputs.
module dcache_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_RESP} state_t;

  state_t                  r_state, w_next;
  logic [LINES-1:0]        r_valid;
  logic [TAG_W-1:0]        r_tag  [LINES];
  logic [31:0]             r_data [LINES];
  logic [ADDR_W-1:0]       r_addr;
  logic [31:0]             r_wdata;
  logic [31:0]             r_rdata;

  logic [INDEX_BITS-1:0]   w_idx, w_lidx;
  logic [TAG_W-1:0]        w_tag, w_ltag;
  logic                    w_hit, w_lhit;
  logic                    w_idle, w_ld_hit, w_fill_start, w_wr_start;
  logic                    w_ready, w_mem_req, w_mem_we;

  assign w_idx  = bus.dataadr[INDEX_BITS+1:2];
  assign w_tag  = bus.dataadr[ADDR_W-1:INDEX_BITS+2];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // Latched-address lookup, used so address changes during a transaction are ignored
  assign w_lidx = r_addr[INDEX_BITS+1:2];
  assign w_ltag = r_addr[ADDR_W-1:INDEX_BITS+2];
  assign w_lhit = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);

  assign w_idle       = (r_state == S_IDLE);
  assign w_wr_start   = w_idle && bus.memwrite;
  assign w_ld_hit     = w_idle && !bus.memwrite && bus.MemtoRegM && w_hit;
  assign w_fill_start = w_idle && !bus.memwrite && bus.MemtoRegM && !w_hit;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_wr_start)        w_next = S_WRITE;
               else if (w_fill_start) w_next = S_FILL;
      S_FILL:  if (bus.mem_ack)       w_next = S_RESP;
      S_WRITE: if (bus.mem_ack)       w_next = S_RESP;
      default:                        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    w_ready   = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = w_ld_hit;
      S_FILL:  w_mem_req = 1'b1;
      S_WRITE: begin w_mem_req = 1'b1; w_mem_we = 1'b1; end
      default: w_ready = 1'b1;
    endcase
  end

  assign bus.MemReady  = w_ready;
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.readdata  = w_ld_hit ? r_data[w_idx] : r_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_wr_start) begin
        r_addr  <= {bus.dataadr[ADDR_W-1:2], 2'b00};
        r_wdata <= bus.writedata;
      end else if (w_fill_start) begin
        r_addr  <= {bus.dataadr[ADDR_W-1:2], 2'b00};
      end
      if (w_ld_hit) r_rdata <= r_data[w_idx];
      if (r_state == S_FILL && bus.mem_ack) begin
        r_valid[w_lidx] <= 1'b1;
        r_rdata         <= bus.mem_rdata;
      end
    end
  end

  // Tag/data arrays carry no reset; validity alone decides whether a line is usable
  always_ff @(posedge clk) begin
    if (!reset && bus.mem_ack) begin
      if (r_state == S_FILL) begin
        r_tag[w_lidx]  <= w_ltag;
        r_data[w_lidx] <= bus.mem_rdata;
      end else if (r_state == S_WRITE && w_lhit) begin
        r_data[w_lidx] <= r_wdata;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (w_ld_hit)     hit_count  <= hit_count + 32'd1;
      if (w_fill_start) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: vector table of loads/stores plus reset-mid-fill and stats sequences.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  dcache_ctrl_if bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
  dcache_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave),
                   .hit_count(hit_count), .miss_count(miss_count));
`else
  dcache_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        miss;   // 1: expect a backing-memory transaction
    int          dly;    // FILL/WRITE cycles before the ack cycle
    logic [31:0] rdata;  // memory return data for a fill
    logic        chk_rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v);
    @(negedge clk);
    bus.memwrite  = v.we;
    bus.MemtoRegM = v.re;
    bus.dataadr   = v.addr;
    bus.writedata = v.wdata;
    bus.mem_ack   = 1'b0;
    #1;
    if (!v.miss) begin
      chk("hit_ready", {31'd0, bus.MemReady}, 32'd1);
      chk("hit_rdata", bus.readdata, v.exp);
      chk("hit_noreq", {31'd0, bus.mem_req}, 32'd0);
      @(posedge clk); #1;
      bus.memwrite  = 1'b0;
      bus.MemtoRegM = 1'b0;
    end else begin
      chk("req_cycle_ready", {31'd0, bus.MemReady}, 32'd0);
      @(posedge clk); #1;
      // Scramble the CPU address; the cache must use its latched copy
      bus.dataadr   = ~v.addr & 32'hFFFF_FFFC;
      bus.writedata = ~v.wdata;
      for (int i = 0; i <= v.dly; i++) begin
        @(negedge clk);
        chk("mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("mem_we", {31'd0, bus.mem_we}, {31'd0, v.we});
        chk("mem_addr", bus.mem_addr, v.addr & 32'hFFFF_FFFC);
        if (v.we) chk("mem_wdata", bus.mem_wdata, v.wdata);
        chk("wait_ready", {31'd0, bus.MemReady}, 32'd0);
        if (i == v.dly) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = v.rdata;
        end
      end
      @(posedge clk); #1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h5A5A_5A5A;
      bus.memwrite  = 1'b0;
      bus.MemtoRegM = 1'b0;
      @(negedge clk);
      chk("resp_ready", {31'd0, bus.MemReady}, 32'd1);
      chk("resp_noreq", {31'd0, bus.mem_req}, 32'd0);
      if (v.chk_rd) chk("resp_rdata", bus.readdata, v.exp);
      @(negedge clk);
      chk("post_ready", {31'd0, bus.MemReady}, 32'd0);
      if (v.chk_rd) chk("post_rdata_hold", bus.readdata, v.exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.memwrite = 1'b0; bus.MemtoRegM = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic vec_t ld(input logic [31:0] a, input logic m, input int d,
                              input logic [31:0] rd, input logic [31:0] e);
    vec_t v;
    v = '{we: 1'b0, re: 1'b1, addr: a, wdata: 32'h0, miss: m, dly: d,
          rdata: rd, chk_rd: 1'b1, exp: e};
    return v;
  endfunction

  function automatic vec_t st(input logic [31:0] a, input logic [31:0] wd, input int d,
                              input logic both);
    vec_t v;
    v = '{we: 1'b1, re: both, addr: a, wdata: wd, miss: 1'b1, dly: d,
          rdata: 32'hEEEE_EEEE, chk_rd: 1'b0, exp: 32'h0};
    return v;
  endfunction

  initial begin
    vecs[0]  = ld(32'h40,  1'b1, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    vecs[1]  = ld(32'h40,  1'b0, 0, 32'h0,         32'hDEAD_BEEF);
    vecs[2]  = st(32'h40,  32'h1234_5678, 1, 1'b0);
    vecs[3]  = ld(32'h40,  1'b0, 0, 32'h0,         32'h1234_5678);
    vecs[4]  = st(32'h80,  32'hAAAA_5555, 0, 1'b0);
    vecs[5]  = ld(32'h40,  1'b0, 0, 32'h0,         32'h1234_5678);
    vecs[6]  = ld(32'h80,  1'b1, 3, 32'h0BAD_F00D, 32'h0BAD_F00D);
    vecs[7]  = ld(32'h42,  1'b1, 0, 32'h1234_5678, 32'h1234_5678);
    vecs[8]  = ld(32'h440, 1'b1, 1, 32'h4404_4044, 32'h4404_4044);
    vecs[9]  = ld(32'h40,  1'b1, 2, 32'h1234_5678, 32'h1234_5678);
    vecs[10] = st(32'h44,  32'hCAFE_F00D, 1, 1'b1);
    vecs[11] = ld(32'h44,  1'b1, 0, 32'h1111_2222, 32'h1111_2222);
    vecs[12] = st(32'h44,  32'h3333_4444, 2, 1'b0);
    vecs[13] = ld(32'h44,  1'b0, 0, 32'h0,         32'h3333_4444);
    vecs[14] = ld(32'h40,  1'b0, 0, 32'h0,         32'h1234_5678);

    reset = 1'b1;
    bus.memwrite = 1'b0; bus.MemtoRegM = 1'b0; bus.dataadr = '0;
    bus.writedata = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.MemReady}, 32'd0);
    chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_rdata", bus.readdata, 32'd0);

    for (int k = 0; k < 15; k++) do_op(vecs[k]);

    // Reset while a fill is outstanding; a late ack must be ignored
    @(negedge clk);
    bus.MemtoRegM = 1'b1; bus.dataadr = 32'h100;
    @(negedge clk);
    chk("rf_req", {31'd0, bus.mem_req}, 32'd1);
    reset = 1'b1; bus.MemtoRegM = 1'b0;
    @(negedge clk);
    chk("rf_req_drop", {31'd0, bus.mem_req}, 32'd0);
    chk("rf_rdata_clr", bus.readdata, 32'd0);
    reset = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h9999_9999;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("rf_late_ack_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rf_late_ack_ready", {31'd0, bus.MemReady}, 32'd0);
    chk("rf_late_ack_rdata", bus.readdata, 32'd0);
    do_op(ld(32'h40, 1'b1, 0, 32'h7777_7777, 32'h7777_7777));

    // Hit/miss statistics sequence from a clean reset
    do_reset();
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    chk("stat_rst_hit", hit_count, 32'd0);
    chk("stat_rst_miss", miss_count, 32'd0);
`endif
    do_op(ld(32'h40,  1'b1, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
    do_op(ld(32'h40,  1'b0, 0, 32'h0,         32'hDEAD_BEEF));
    do_op(ld(32'h440, 1'b1, 0, 32'h4404_4044, 32'h4404_4044));
    do_op(ld(32'h40,  1'b1, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    chk("stat_hit", hit_count, 32'd1);
    chk("stat_miss", miss_count, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
